// File: rtl/input_matrix_control_unit_if.sv
// Handshake bundle between the frame sequencer, the FIFO-to-BRAM write unit
// and the window stage.
interface input_matrix_control_unit_if;
  logic       start;
  logic       req_pix;
  logic       new_line;
  logic       pix_ctrl_ack;
  logic [1:0] line_sel;
  logic [3:0] col_cnt;
  logic [7:0] row_cnt;
  logic       line_done;
  logic       rows_valid;
  logic       proc_line_done;
  logic       busy;
  logic       done;

  modport master (
    input  start,
    input  pix_ctrl_ack,
    input  proc_line_done,
    output req_pix,
    output new_line,
    output line_sel,
    output col_cnt,
    output row_cnt,
    output line_done,
    output rows_valid,
    output busy,
    output done
  );

  modport slave (
    output start,
    output pix_ctrl_ack,
    output proc_line_done,
    input  req_pix,
    input  new_line,
    input  line_sel,
    input  col_cnt,
    input  row_cnt,
    input  line_done,
    input  rows_valid,
    input  busy,
    input  done
  );
endinterface

// File: rtl/input_matrix_control_unit.sv
// Frame sequencer: writes each image line into one of KERNEL_DIMM rotating line
// buffers and holds off overwriting the oldest line until the window stage frees it.
module input_matrix_control_unit #(
  parameter int unsigned KERNEL_DIMM = 3,
  parameter int unsigned BRAM_WIDTH  = 4,
  parameter int unsigned IMG_HEIGHT  = 8
) (
  input logic                          clk,
  input logic                          reset,
  input_matrix_control_unit_if.master  ctrl
);

  localparam int unsigned LlW = $clog2(KERNEL_DIMM + 1);

  localparam logic [3:0]     ColLast = 4'(BRAM_WIDTH - 1);
  localparam logic [7:0]     RowFull = 8'(IMG_HEIGHT);
  localparam logic [1:0]     SelLast = 2'(KERNEL_DIMM - 1);
  localparam logic [LlW-1:0] LlFull  = LlW'(KERNEL_DIMM);
  localparam logic [LlW-1:0] LlOne   = LlW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StNewLine,
    StReq,
    StLineEnd,
    StWaitProc,
    StDone
  } state_e;

  state_e         state_q;
  logic           req_pix_q;
  logic           new_line_q;
  logic           line_done_q;
  logic           rows_valid_q;
  logic           busy_q;
  logic           done_q;
  logic           pending_q;
  logic [1:0]     line_sel_q;
  logic [3:0]     col_cnt_q;
  logic [7:0]     row_cnt_q;
  logic [LlW-1:0] lines_loaded_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      req_pix_q      <= 1'b0;
      new_line_q     <= 1'b0;
      line_done_q    <= 1'b0;
      rows_valid_q   <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pending_q      <= 1'b0;
      line_sel_q     <= '0;
      col_cnt_q      <= '0;
      row_cnt_q      <= '0;
      lines_loaded_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (ctrl.start) begin
            row_cnt_q      <= '0;
            line_sel_q     <= '0;
            lines_loaded_q <= '0;
            pending_q      <= 1'b0;
            rows_valid_q   <= 1'b0;
            busy_q         <= 1'b1;
            new_line_q     <= 1'b1;
            state_q        <= StNewLine;
          end
        end

        StNewLine: begin
          if (ctrl.proc_line_done) pending_q <= 1'b1;
          new_line_q <= 1'b0;
          col_cnt_q  <= '0;
          req_pix_q  <= 1'b1;
          state_q    <= StReq;
        end

        StReq: begin
          if (ctrl.proc_line_done) pending_q <= 1'b1;
          if (ctrl.pix_ctrl_ack) begin
            col_cnt_q <= col_cnt_q + 4'd1;
            // Line bookkeeping is committed on the last ack so that line_done,
            // row_cnt, line_sel and rows_valid all change in the same cycle.
            if (col_cnt_q == ColLast) begin
              req_pix_q   <= 1'b0;
              line_done_q <= 1'b1;
              row_cnt_q   <= row_cnt_q + 8'd1;
              line_sel_q  <= (line_sel_q == SelLast) ? 2'd0 : line_sel_q + 2'd1;
              if (lines_loaded_q != LlFull) lines_loaded_q <= lines_loaded_q + LlOne;
              if (lines_loaded_q >= LlFull - LlOne) rows_valid_q <= 1'b1;
              state_q     <= StLineEnd;
            end
          end
        end

        StLineEnd: begin
          if (ctrl.proc_line_done) pending_q <= 1'b1;
          line_done_q <= 1'b0;
          // row_cnt and lines_loaded already hold their post-line values here.
          if (row_cnt_q == RowFull) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else if (lines_loaded_q == LlFull) begin
            state_q <= StWaitProc;
          end else begin
            new_line_q <= 1'b1;
            state_q    <= StNewLine;
          end
        end

        StWaitProc: begin
          if (ctrl.proc_line_done || pending_q) begin
            pending_q  <= 1'b0;
            new_line_q <= 1'b1;
            state_q    <= StNewLine;
          end
        end

        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign ctrl.req_pix    = req_pix_q;
  assign ctrl.new_line   = new_line_q;
  assign ctrl.line_sel   = line_sel_q;
  assign ctrl.col_cnt    = col_cnt_q;
  assign ctrl.row_cnt    = row_cnt_q;
  assign ctrl.line_done  = line_done_q;
  assign ctrl.rows_valid = rows_valid_q;
  assign ctrl.busy       = busy_q;
  assign ctrl.done       = done_q;

endmodule

// File: tb/tb_input_matrix_control_unit.sv
// Directed bench for input_matrix_control_unit: frame sequencing, back-pressure,
// hold-off, early credit, spurious inputs and mid-line reset.
module tb_input_matrix_control_unit;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  input_matrix_control_unit_if bus_if ();

  input_matrix_control_unit #(
    .KERNEL_DIMM (3),
    .BRAM_WIDTH  (4),
    .IMG_HEIGHT  (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus_if)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return {12'd0, bus_if.req_pix, bus_if.new_line, bus_if.line_done, bus_if.rows_valid,
            bus_if.busy, bus_if.done, bus_if.line_sel, bus_if.col_cnt, bus_if.row_cnt};
  endfunction

  function automatic logic in_wait();
    return bus_if.busy && !bus_if.req_pix && !bus_if.new_line && !bus_if.line_done &&
           !bus_if.done;
  endfunction

  task automatic reset_dut();
    reset                 = 1'b1;
    bus_if.start          = 1'b0;
    bus_if.pix_ctrl_ack   = 1'b0;
    bus_if.proc_line_done = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] sel_seq;
    logic [31:0] nl1;
    logic        rv2;
    logic        rv3;
    logic        bp_ok;
    logic        park_ok;
    logic        w19;
    logic        park30;
    logic        found;
    logic [2:0]  nl20;
    int          n_ld;
    int          first_ld;
    int          done_cyc;
    int          row_at_done;
    int          n;

    // Reset state
    reset                 = 1'b1;
    bus_if.start          = 1'b0;
    bus_if.pix_ctrl_ack   = 1'b0;
    bus_if.proc_line_done = 1'b0;
    tick();
    tick();
    check_eq("reset_outs", outs(), 32'd0);
    reset = 1'b0;
    tick();
    check_eq("idle_outs", outs(), 32'd0);

    // Single frame, ack tied high, proc_line_done pulsed whenever parked
    bus_if.pix_ctrl_ack = 1'b1;
    bus_if.start        = 1'b1;
    sel_seq = '0; n_ld = 0; first_ld = 0; done_cyc = 0; row_at_done = 0;
    nl1 = '0; rv2 = 1'b1; rv3 = 1'b0;
    for (int cyc = 1; cyc <= 100 && done_cyc == 0; cyc++) begin
      tick();
      bus_if.start = 1'b0;
      if (cyc == 1) nl1 = {30'd0, bus_if.new_line, bus_if.busy};
      if (bus_if.new_line) sel_seq = {sel_seq[13:0], bus_if.line_sel};
      if (bus_if.line_done) begin
        n_ld++;
        if (first_ld == 0) first_ld = cyc;
        if (n_ld == 2) rv2 = bus_if.rows_valid;
        if (n_ld == 3) rv3 = bus_if.rows_valid;
      end
      bus_if.proc_line_done = in_wait();
      if (bus_if.done) begin
        done_cyc     = cyc;
        row_at_done  = int'(bus_if.row_cnt);
        bus_if.start = 1'b1;  // start coinciding with done must be ignored
      end
    end
    check_eq("f_cycle1_newline_busy", nl1, 32'd3);
    check_eq("f_first_line_done_cyc", first_ld, 6);
    check_eq("f_rows_valid_ld2", {31'd0, rv2}, 32'd0);
    check_eq("f_rows_valid_ld3", {31'd0, rv3}, 32'd1);
    check_eq("f_line_done_count", n_ld, 8);
    check_eq("f_line_sel_seq", {16'd0, sel_seq}, 32'h1861);
    check_eq("f_done_cycle", done_cyc, 54);
    check_eq("f_row_at_done", row_at_done, 8);
    tick();
    bus_if.start = 1'b0;
    check_eq("f_start_at_done_ignored", {30'd0, bus_if.busy, bus_if.new_line}, 32'd0);
    tick();
    check_eq("f_idle_after_done", {23'd0, bus_if.busy, bus_if.row_cnt}, 32'd8);

    // Back-pressure mid-line
    reset_dut();
    bus_if.pix_ctrl_ack = 1'b1;
    bus_if.start        = 1'b1;
    tick();
    bus_if.start = 1'b0;
    tick();
    tick();
    tick();
    check_eq("bp_col_before_stall", bus_if.col_cnt, 2);
    bus_if.pix_ctrl_ack = 1'b0;
    bp_ok = 1'b1;
    repeat (5) begin
      tick();
      if (!(bus_if.req_pix && bus_if.col_cnt == 4'd2)) bp_ok = 1'b0;
    end
    check_eq("bp_frozen", {31'd0, bp_ok}, 32'd1);
    bus_if.pix_ctrl_ack = 1'b1;
    tick();
    check_eq("bp_resume_col", {27'd0, bus_if.req_pix, bus_if.col_cnt}, 32'h13);
    tick();
    check_eq("bp_line_end", {26'd0, bus_if.line_done, bus_if.req_pix, bus_if.col_cnt},
             32'h24);

    // Hold-off: no proc_line_done, FSM parks after the third line
    n = 0;
    for (int i = 0; i < 40 && n < 2; i++) begin
      tick();
      if (bus_if.line_done) n++;
    end
    check_eq("hold_third_line", {23'd0, bus_if.rows_valid, bus_if.row_cnt}, 32'h103);
    tick();
    park_ok      = 1'b1;
    bus_if.start = 1'b1;  // spurious start while busy, ack still high
    repeat (20) begin
      if (!in_wait() || bus_if.col_cnt != 4'd4 || bus_if.row_cnt != 8'd3) park_ok = 1'b0;
      tick();
    end
    bus_if.start = 1'b0;
    check_eq("hold_parked", {31'd0, park_ok}, 32'd1);
    check_eq("hold_still_parked", {31'd0, in_wait()}, 32'd1);
    bus_if.proc_line_done = 1'b1;
    tick();
    bus_if.proc_line_done = 1'b0;
    check_eq("hold_release", {29'd0, bus_if.new_line, bus_if.line_sel}, 32'h4);

    // Early credit during the third line's REQ
    reset_dut();
    bus_if.pix_ctrl_ack = 1'b1;
    bus_if.start        = 1'b1;
    w19 = 1'b0; nl20 = '0; park30 = 1'b0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      tick();
      bus_if.start          = 1'b0;
      bus_if.proc_line_done = (cyc == 15);
      if (cyc == 19) w19 = in_wait();
      if (cyc == 20) nl20 = {bus_if.new_line, bus_if.line_sel};
      if (cyc == 30) park30 = in_wait();
    end
    check_eq("credit_wait_cyc19", {31'd0, w19}, 32'd1);
    check_eq("credit_newline_cyc20", {29'd0, nl20}, 32'h4);
    check_eq("credit_cleared_parks", {31'd0, park30}, 32'd1);

    // Reset mid-line at row_cnt=3, col_cnt=2
    reset_dut();
    bus_if.pix_ctrl_ack = 1'b1;
    bus_if.start        = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      bus_if.start = 1'b0;
      if (bus_if.row_cnt == 8'd3 && bus_if.col_cnt == 4'd2 && bus_if.req_pix) found = 1'b1;
      bus_if.proc_line_done = in_wait();
    end
    check_eq("rst_mid_reached", {31'd0, found}, 32'd1);
    reset = 1'b1;
    tick();
    check_eq("rst_mid_outs", outs(), 32'd0);
    reset        = 1'b0;
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    check_eq("rst_restart",
             {19'd0, bus_if.row_cnt, bus_if.line_sel, bus_if.rows_valid, bus_if.new_line,
              bus_if.busy}, 32'h3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/input_matrix_control_unit.md
Name: input_matrix_control_unit

Overview:
Frame-level sequencer directly upstream of the FIFO-to-BRAM write unit. It drives that unit's req_pix / new_line / pix_ctrl_ack handshake so that each image line is written, one pixel per ack, into one of KERNEL_DIMM rotating line buffers. It counts columns and rows and tracks which line buffer is active. Once KERNEL_DIMM lines are resident, it holds off overwriting the oldest line until the downstream window stage releases it.

Parameters:
KERNEL_DIMM, 3, number of line buffers / kernel rows
BRAM_WIDTH, 4, pixels per line (one BRAM address per pixel)
IMG_HEIGHT, 8, lines per frame

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  frame start pulse; ignored while busy=1
req_pix  output  1  pixel request to write unit
new_line  output  1  one-cycle pulse; write unit restarts line address at 0
pix_ctrl_ack  input  1  one pixel written this cycle
line_sel  output  2  index of line buffer being written, 0..KERNEL_DIMM-1
col_cnt  output  4  pixels written in current line
row_cnt  output  8  lines completed in current frame
line_done  output  1  one-cycle pulse at end of each line
rows_valid  output  1  KERNEL_DIMM lines resident; window stage may read
proc_line_done  input  1  pulse from window stage: oldest line no longer needed
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse after last line of frame

Behaviour:
- Reset: all outputs 0; state IDLE; pending flag 0; lines_loaded 0.
- States: IDLE, NEW_LINE, REQ, LINE_END, WAIT_PROC, DONE.
- IDLE: busy=0. On start: clear row_cnt, line_sel, lines_loaded, pending, rows_valid; go to NEW_LINE. busy=1 from the next cycle.
- NEW_LINE: new_line=1 for exactly 1 cycle; col_cnt<=0; go to REQ.
- REQ: req_pix=1 continuously, back-to-back allowed. Each cycle with pix_ctrl_ack=1 increments col_cnt. The ack for pixel BRAM_WIDTH-1 moves to LINE_END; req_pix drops in the same edge. Line latency is therefore 1 + BRAM_WIDTH + 1 cycles with continuous ack.
- pix_ctrl_ack while req_pix=0 is ignored: no count, no state change.
- LINE_END: line_done=1 for 1 cycle.
  - row_cnt++.
  - line_sel wraps KERNEL_DIMM-1 -> 0.
  - lines_loaded saturates at KERNEL_DIMM; rows_valid=1 once it equals KERNEL_DIMM. rows_valid stays 1 until the next start or reset.
  - Next state: if row_cnt (pre-increment) == IMG_HEIGHT-1, go to DONE. Else if lines_loaded (post-update) == KERNEL_DIMM, go to WAIT_PROC. Else go to NEW_LINE.
- WAIT_PROC: req_pix=0. Leave to NEW_LINE on the first cycle where proc_line_done=1 or pending=1; clear pending on exit.
- proc_line_done in any other busy state sets pending (1-deep credit). A second pulse while pending=1 is lost. proc_line_done is ignored in IDLE and DONE.
- DONE: done=1 for 1 cycle, busy=0 from the next cycle; go to IDLE. row_cnt holds IMG_HEIGHT until the next start.
- A start that coincides with done is ignored; start is accepted only in IDLE.
- Reset mid-operation: at the next edge all outputs and state return to reset values. A req_pix high level is dropped with no pixel counted.
- Widths: col_cnt wraps never (max BRAM_WIDTH ≤ 15). row_cnt max IMG_HEIGHT ≤ 255. line_sel modulo KERNEL_DIMM.

Test Plan:
- Single frame, ack tied high, proc_line_done pulsed in WAIT_PROC: start -> new_line at cycle 1; 4 req/ack cycles; line_done at cycle 6. rows_valid rises with the 3rd line_done. done after 8 line_done pulses; line_sel sequence 0,1,2,0,1,2,0,1.
- Back-pressure: ack low for 5 cycles mid-line -> req_pix stays high, col_cnt frozen at 2, resumes with no lost or extra pixels.
- Hold-off: proc_line_done never pulsed -> FSM parks in WAIT_PROC after 3rd line; req_pix=0 indefinitely. A later pulse -> new_line next cycle, line_sel=0.
- Early credit: proc_line_done pulsed during 3rd line's REQ -> WAIT_PROC lasts exactly 1 cycle, pending cleared.
- Spurious inputs: ack with req_pix=0, and start while busy -> no counter or state change.
- Reset mid-line (col_cnt=2, row_cnt=3) -> next cycle all outputs 0, state IDLE. A new start -> row_cnt 0, line_sel 0, rows_valid 0.
